// File: rtl/counter_pkg.sv
// Shared types and constants for the counter subsystem (up-counter and countdown timer).
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    EXPIRED
  } cd_state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with terminal-count pulse; one-shot or auto-reload.
module countdown_timer
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             mode,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             expired
);

  localparam logic [WIDTH-1:0] CountZero = '0;
  localparam logic [WIDTH-1:0] CountOne  = WIDTH'(1);

  cd_state_t        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;

    if (load) begin
      count_d  = data;
      reload_d = data;
      mode_d   = mode;
      if (data != CountZero) begin
        state_d = ARMED;
      end else begin
        // Zero-length timeout expires immediately, even in auto-reload.
        state_d = EXPIRED;
        tc_d    = 1'b1;
      end
    end else if (enable && (state_q == ARMED)) begin
      if (count_q > CountOne) begin
        count_d = count_q - CountOne;
      end else if (count_q == CountOne) begin
        count_d = CountZero;
        tc_d    = 1'b1;
        if (mode_q == MODE_ONESHOT) begin
          state_d = EXPIRED;
        end
      end else begin
        // Zero while armed only occurs in auto-reload: start the next period.
        count_d = reload_q;
        if (reload_q == CountZero) begin
          state_d = EXPIRED;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= CountZero;
      reload_q <= CountZero;
      mode_q   <= MODE_ONESHOT;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign busy    = (state_q == ARMED);
  assign expired = (state_q == EXPIRED);

endmodule
